// File: rtl/debug_hex_overlay_pkg.sv
// Shared constants and the 8x8 glyph set for the debug hex overlay.
// Glyph codes 0-15 are hex digits, 16 is the minus sign and 17 is blank.
package debug_hex_overlay_pkg;

    localparam int         GLYPH_W     = 5;
    localparam logic [4:0] GLYPH_MINUS = 5'd16;
    localparam logic [4:0] GLYPH_BLANK = 5'd17;
    localparam int         LINE_PITCH  = 16;
    localparam int         SEQ_LEN_DEF = 16;
    localparam int         DIGITS      = SEQ_LEN_DEF / 4 + 1;

    // Row 0 is the top byte of the returned word; bit 7 of a row is the leftmost pixel.
    function automatic logic [63:0] font_glyph(input logic [GLYPH_W-1:0] code);
        logic [63:0] g;
        case (code)
            5'd0:    g = 64'h3C666E7666663C00;
            5'd1:    g = 64'h1838181818187E00;
            5'd2:    g = 64'h3C66060C30607E00;
            5'd3:    g = 64'h3C66061C06663C00;
            5'd4:    g = 64'h0C1C3C6C7E0C0C00;
            5'd5:    g = 64'h7E607C0606663C00;
            5'd6:    g = 64'h3C607C6666663C00;
            5'd7:    g = 64'h7E060C1830303000;
            5'd8:    g = 64'h3C66663C66663C00;
            5'd9:    g = 64'h3C66663E060C3800;
            5'd10:   g = 64'h183C66667E666600;
            5'd11:   g = 64'h7C66667C66667C00;
            5'd12:   g = 64'h3C66606060663C00;
            5'd13:   g = 64'h786C6666666C7800;
            5'd14:   g = 64'h7E60607C60607E00;
            5'd15:   g = 64'h7E60607C60606000;
            5'd16:   g = 64'h0000007E00000000;
            default: g = 64'h0000000000000000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/debug_hex_overlay_font_rom.sv
// 18-glyph x 8-row font ROM with a registered row-byte output.
// One-cycle read latency; the output only advances when en is high.
module hex_font_rom
    import debug_hex_overlay_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [GLYPH_W-1:0] code,
    input  logic [2:0]         row,
    output logic [7:0]         data
);

    logic [7:0]  data_d;
    logic [7:0]  data_q;
    logic [63:0] glyph_s;
    logic [63:0] row_word_s;

    // Look up the glyph and extract the requested row byte.
    always_comb begin
        glyph_s    = font_glyph(code);
        row_word_s = glyph_s >> {3'd7 - row, 3'b000};
        if (en) begin
            data_d = row_word_s[7:0];
        end else begin
            data_d = data_q;
        end
    end

    // Row byte register.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 8'h00;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/debug_hex_overlay.sv
// Debug panel text renderer: per-frame snapshot of signed values, 3-stage pixel pipeline
// producing an overlay enable/colour that lines up with the pixel presented 3 p_ticks earlier.
module debug_hex_overlay
    import debug_hex_overlay_pkg::*;
#(
    parameter int                     SEQ_LEN     = SEQ_LEN_DEF,
    parameter int                     SEQ_NUM     = 16,
    parameter int                     FONT_WIDTH  = 8,
    parameter int                     PIXEL_WIDTH = 12,
    parameter int                     OVL_X0      = 8,
    parameter int                     OVL_Y0      = 8,
    parameter logic [PIXEL_WIDTH-1:0] FG_COLOR    = 12'hFFF
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       p_tick,
    input  logic                       video_on,
    input  logic [9:0]                 x,
    input  logic [9:0]                 y,
    input  logic [SEQ_NUM*SEQ_LEN-1:0] values,
    output logic                       ovl_on,
    output logic [PIXEL_WIDTH-1:0]     ovl_rgb
);

    localparam int NDIG   = SEQ_LEN / 4 + 1;
    localparam int LINE_W = (SEQ_NUM > 1) ? $clog2(SEQ_NUM) : 1;
    localparam int DIG_W  = $clog2(NDIG);
    localparam logic [SEQ_LEN-1:0] ONE_V = 1;

    logic [SEQ_LEN-1:0] snap_d [SEQ_NUM];
    logic [SEQ_LEN-1:0] snap_q [SEQ_NUM];

    logic              in1_d, in1_q, von1_d, von1_q;
    logic [LINE_W-1:0] line1_d, line1_q;
    logic [DIG_W-1:0]  dig1_d, dig1_q;
    logic [2:0]        row1_d, row1_q, col1_d, col1_q;

    logic              in2_d, in2_q, von2_d, von2_q;
    logic [2:0]        col2_d, col2_q;

    logic                   ovl_on_d, ovl_on_q;
    logic [PIXEL_WIDTH-1:0] ovl_rgb_d, ovl_rgb_q;

    logic [9:0]         dx_s, dy_s, line_full_s, dig_full_s;
    logic [3:0]         row_full_s;
    logic               in_s;
    logic [SEQ_LEN-1:0] sel_s, mag_s, nib_word_s;
    logic               neg_s, on_s;
    logic [GLYPH_W-1:0] code_s;
    logic [7:0]         rowbyte_s;

    // Snapshot next-state: capture every value on the (0,0) pixel tick.
    always_comb begin
        for (int i = 0; i < SEQ_NUM; i++) begin
            if (p_tick && (x == 10'd0) && (y == 10'd0)) begin
                snap_d[i] = values[i*SEQ_LEN +: SEQ_LEN];
            end else begin
                snap_d[i] = snap_q[i];
            end
        end
    end

    // Stage 1: panel-relative coordinates and the in-panel test.
    always_comb begin
        dx_s        = x - 10'(OVL_X0);
        dy_s        = y - 10'(OVL_Y0);
        line_full_s = dy_s >> $clog2(LINE_PITCH);
        row_full_s  = dy_s[3:0];
        dig_full_s  = dx_s >> 3;
        in_s = (x >= 10'(OVL_X0)) && (y >= 10'(OVL_Y0))
            && (32'(line_full_s) < SEQ_NUM)
            && (32'(dig_full_s) <= SEQ_LEN / 4)
            && (32'(row_full_s) < FONT_WIDTH);
        if (p_tick) begin
            in1_d   = in_s;
            von1_d  = video_on;
            line1_d = line_full_s[LINE_W-1:0];
            dig1_d  = dig_full_s[DIG_W-1:0];
            row1_d  = row_full_s[2:0];
            col1_d  = dx_s[2:0];
        end else begin
            in1_d   = in1_q;
            von1_d  = von1_q;
            line1_d = line1_q;
            dig1_d  = dig1_q;
            row1_d  = row1_q;
            col1_d  = col1_q;
        end
    end

    // Stage 2: pick sign or magnitude nibble as the glyph code; the ROM registers the row byte.
    always_comb begin
        sel_s      = snap_q[line1_q];
        neg_s      = sel_s[SEQ_LEN-1];
        mag_s      = neg_s ? (~sel_s + ONE_V) : sel_s;
        nib_word_s = mag_s >> (4 * (NDIG - 1 - int'(dig1_q)));
        if (dig1_q == {DIG_W{1'b0}}) begin
            code_s = neg_s ? GLYPH_MINUS : GLYPH_BLANK;
        end else begin
            code_s = {1'b0, nib_word_s[3:0]};
        end
        if (p_tick) begin
            in2_d  = in1_q;
            von2_d = von1_q;
            col2_d = col1_q;
        end else begin
            in2_d  = in2_q;
            von2_d = von2_q;
            col2_d = col2_q;
        end
    end

    hex_font_rom u_font (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .en   (p_tick),
        .code (code_s),
        .row  (row1_q),
        .data (rowbyte_s)
    );

    // Stage 3: pixel bit select and colour.
    always_comb begin
        on_s = in2_q && von2_q && rowbyte_s[3'd7 - col2_q];
        if (p_tick) begin
            ovl_on_d  = on_s;
            ovl_rgb_d = on_s ? FG_COLOR : {PIXEL_WIDTH{1'b0}};
        end else begin
            ovl_on_d  = ovl_on_q;
            ovl_rgb_d = ovl_rgb_q;
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < SEQ_NUM; i++) begin
                snap_q[i] <= {SEQ_LEN{1'b0}};
            end
            in1_q     <= 1'b0;
            von1_q    <= 1'b0;
            line1_q   <= {LINE_W{1'b0}};
            dig1_q    <= {DIG_W{1'b0}};
            row1_q    <= 3'd0;
            col1_q    <= 3'd0;
            in2_q     <= 1'b0;
            von2_q    <= 1'b0;
            col2_q    <= 3'd0;
            ovl_on_q  <= 1'b0;
            ovl_rgb_q <= {PIXEL_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < SEQ_NUM; i++) begin
                snap_q[i] <= snap_d[i];
            end
            in1_q     <= in1_d;
            von1_q    <= von1_d;
            line1_q   <= line1_d;
            dig1_q    <= dig1_d;
            row1_q    <= row1_d;
            col1_q    <= col1_d;
            in2_q     <= in2_d;
            von2_q    <= von2_d;
            col2_q    <= col2_d;
            ovl_on_q  <= ovl_on_d;
            ovl_rgb_q <= ovl_rgb_d;
        end
    end

    assign ovl_on  = ovl_on_q;
    assign ovl_rgb = ovl_rgb_q;

endmodule

// File: tb/tb_debug_hex_overlay.sv
// Directed bench for debug_hex_overlay: hand-computed pixel vectors plus a per-tick reference stream.
module tb_debug_hex_overlay;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         p_tick;
    logic         video_on;
    logic [9:0]   x;
    logic [9:0]   y;
    logic [255:0] values;
    logic         ovl_on;
    logic [11:0]  ovl_rgb;

    always #5 sys_clk = ~sys_clk;

    debug_hex_overlay dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .p_tick   (p_tick),
        .video_on (video_on),
        .x        (x),
        .y        (y),
        .values   (values),
        .ovl_on   (ovl_on),
        .ovl_rgb  (ovl_rgb)
    );

    typedef struct {
        int    px;
        int    py;
        bit    von;
        bit    exp_on;
        string name;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] font_m [18];
    logic [15:0] snap_m [16];
    bit          exp_q [$];
    vec_t        tbl_a [$];
    vec_t        tbl_b [$];

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Reference pixel: panel at (8,8), 16-pixel line pitch, 5 glyphs of 8 pixels.
    function automatic bit model_px(input int px, input int py, input bit von);
        int          dx, dy, ln, row, dig, col, code;
        logic [15:0] v, mag;
        logic [63:0] g;
        if (!von || px < 8 || py < 8) return 1'b0;
        dx = px - 8; dy = py - 8;
        ln = dy / 16; row = dy % 16; dig = dx / 8; col = dx % 8;
        if (ln >= 16 || dig > 4 || row >= 8) return 1'b0;
        v   = snap_m[ln];
        mag = v[15] ? (~v + 16'd1) : v;
        if (dig == 0) code = v[15] ? 16 : 17;
        else          code = int'((mag >> (4 * (4 - dig))) & 16'h000F);
        g = font_m[code];
        return g[63 - 8 * row - col];
    endfunction

    task automatic tick(input int px, input int py, input bit von);
        bit e;
        x = 10'(px); y = 10'(py); video_on = von; p_tick = 1'b1;
        @(posedge sys_clk); #1;
        p_tick = 1'b0;
        if (px == 0 && py == 0) begin
            for (int i = 0; i < 16; i++) snap_m[i] = values[i*16 +: 16];
        end
        exp_q.push_back(model_px(px, py, von));
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            check($sformatf("stream_on@tick(%0d,%0d)", px, py), int'(ovl_on), int'(e));
            check($sformatf("stream_rgb@tick(%0d,%0d)", px, py), int'(ovl_rgb), e ? 4095 : 0);
        end
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_vec(input int px, input int py, input bit von, input bit expv, input string name);
        tick(px, py, von);
        tick(1000, 1000, 1'b0);
        tick(1000, 1000, 1'b0);
        check({name, "_on"}, int'(ovl_on), int'(expv));
        check({name, "_rgb"}, int'(ovl_rgb), expv ? 4095 : 0);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; p_tick = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        check("reset_on", int'(ovl_on), 0);
        check("reset_rgb", int'(ovl_rgb), 0);
        for (int i = 0; i < 16; i++) snap_m[i] = 16'h0000;
        exp_q.delete();
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          hold_on;
        logic [11:0] hold_rgb;

        font_m = '{64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00,
                   64'h3C66061C06663C00, 64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
                   64'h3C607C6666663C00, 64'h7E060C1830303000, 64'h3C66663C66663C00,
                   64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
                   64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00,
                   64'h7E60607C60606000, 64'h0000007E00000000, 64'h0000000000000000};

        // Line 0 = 0x1234 (" 1234"), line 3 = 0xFFFF ("-0001"), plus out-of-panel pixels.
        tbl_a.push_back('{19, 8, 1'b1, 1'b1, "one_r0_c3"});
        tbl_a.push_back('{18, 8, 1'b1, 1'b0, "one_r0_c2"});
        tbl_a.push_back('{20, 8, 1'b1, 1'b1, "one_r0_c4"});
        tbl_a.push_back('{21, 8, 1'b1, 1'b0, "one_r0_c5"});
        tbl_a.push_back('{17, 14, 1'b1, 1'b1, "one_r6_c1"});
        tbl_a.push_back('{16, 14, 1'b1, 1'b0, "one_r6_c0"});
        tbl_a.push_back('{26, 12, 1'b1, 1'b1, "two_r4_c2"});
        tbl_a.push_back('{28, 12, 1'b1, 1'b0, "two_r4_c4"});
        tbl_a.push_back('{41, 12, 1'b1, 1'b1, "four_r4_c1"});
        tbl_a.push_back('{11, 8, 1'b1, 1'b0, "blank_sign"});
        tbl_a.push_back('{9, 59, 1'b1, 1'b1, "minus_r3_c1"});
        tbl_a.push_back('{8, 59, 1'b1, 1'b0, "minus_r3_c0"});
        tbl_a.push_back('{43, 56, 1'b1, 1'b1, "ffff_d4_one"});
        tbl_a.push_back('{18, 56, 1'b1, 1'b1, "ffff_d1_zero_c2"});
        tbl_a.push_back('{16, 56, 1'b1, 1'b0, "ffff_d1_zero_c0"});
        tbl_a.push_back('{19, 16, 1'b1, 1'b0, "gap_row8"});
        tbl_a.push_back('{19, 8, 1'b0, 1'b0, "video_off"});
        tbl_a.push_back('{3, 8, 1'b1, 1'b0, "left_of_panel"});
        tbl_a.push_back('{51, 8, 1'b1, 1'b0, "digit5"});
        tbl_a.push_back('{19, 264, 1'b1, 1'b0, "line16"});
        // Line 3 = 0x8000 ("-8000").
        tbl_b.push_back('{18, 56, 1'b1, 1'b1, "m8000_eight_c2"});
        tbl_b.push_back('{17, 56, 1'b1, 1'b0, "m8000_eight_c1"});
        tbl_b.push_back('{9, 59, 1'b1, 1'b1, "m8000_minus"});
        tbl_b.push_back('{25, 59, 1'b1, 1'b1, "m8000_zero_r3_c1"});
        tbl_b.push_back('{24, 59, 1'b1, 1'b0, "m8000_zero_r3_c0"});

        values = '0; x = 10'd0; y = 10'd0; video_on = 1'b0; p_tick = 1'b0; sys_rst = 1'b0;
        #1;
        do_reset();
        tick(500, 500, 1'b1);
        tick(500, 500, 1'b1);
        tick(19, 8, 1'b1);

        values[0*16 +: 16] = 16'h1234;
        values[3*16 +: 16] = 16'hFFFF;
        tick(0, 0, 1'b1);
        foreach (tbl_a[i]) apply_vec(tbl_a[i].px, tbl_a[i].py, tbl_a[i].von, tbl_a[i].exp_on, tbl_a[i].name);

        values[3*16 +: 16] = 16'h8000;
        tick(0, 0, 1'b1);
        foreach (tbl_b[i]) apply_vec(tbl_b[i].px, tbl_b[i].py, tbl_b[i].von, tbl_b[i].exp_on, tbl_b[i].name);

        // Mid-frame value change must not appear until the next (0,0).
        values[0*16 +: 16] = 16'h0005;
        tick(0, 0, 1'b1);
        apply_vec(41, 11, 1'b1, 1'b0, "five_r3_c1");
        values[0*16 +: 16] = 16'h0006;
        tick(100, 100, 1'b1);
        apply_vec(41, 11, 1'b1, 1'b0, "still_five");
        tick(0, 0, 1'b1);
        apply_vec(41, 11, 1'b1, 1'b1, "six_r3_c1");

        // Stalled p_tick: outputs hold, stream continues with no skipped pixel.
        for (int px = 8; px < 48; px++) begin
            tick(px, 9, 1'b1);
            if (px == 28) begin
                hold_on  = ovl_on;
                hold_rgb = ovl_rgb;
                repeat (20) @(posedge sys_clk);
                #1;
                check("stall_hold_on", int'(ovl_on), int'(hold_on));
                check("stall_hold_rgb", int'(ovl_rgb), int'(hold_rgb));
            end
        end

        // Mid-frame reset clears pipeline and snapshot.
        apply_vec(45, 9, 1'b1, 1'b0, "six_r1_c5");
        apply_vec(19, 8, 1'b1, 1'b1, "pre_reset_lit");
        do_reset();
        for (int px = 8; px < 48; px++) tick(px, 8, 1'b1);
        apply_vec(45, 9, 1'b1, 1'b1, "zero_snap_r1_c5");
        tick(0, 0, 1'b1);
        apply_vec(45, 9, 1'b1, 1'b0, "resnap_six_r1_c5");
        for (int px = 8; px < 48; px++) tick(px, 9, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
